// File: rtl/jedro_1_pkg.sv
// Shared constants, types and port-slicing helper for the jedro_1 register file.
package jedro_1_pkg;
  localparam int unsigned RV32I_NUM_REGS = 32;
  localparam int unsigned RV32E_NUM_REGS = 16;
  localparam int unsigned SLICE_VEC_W    = 1024;
  localparam int unsigned SLICE_MAX_W    = 64;

  typedef logic [$clog2(RV32I_NUM_REGS)-1:0] reg_addr_t;

  // Field idx of a packed per-port vector; callers zero-extend the vector and truncate the result.
  function automatic logic [SLICE_MAX_W-1:0] port_slice(input logic [SLICE_VEC_W-1:0] vec,
                                                       input int unsigned idx,
                                                       input int unsigned width);
    logic [SLICE_MAX_W-1:0] mask;
    mask = (width >= SLICE_MAX_W) ? '1 : ((SLICE_MAX_W'(1) << width) - SLICE_MAX_W'(1));
    return SLICE_MAX_W'(vec >> (idx * width)) & mask;
  endfunction
endpackage

// File: rtl/jedro_1_scoreboard.sv
// Busy-bit scoreboard: one pending bit per register, flush > issue > retire.
module jedro_1_scoreboard
  import jedro_1_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_WR_PORTS   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr [NUM_WR_PORTS],
  input  logic [NUM_WR_PORTS-1:0]   wr_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] iss_addr_i,
  input  logic                      iss_valid_i,
  input  logic                      flush_i,
  output logic                      iss_ready_co,
  output logic [NUM_REGS-1:0]       pend
);
  logic [NUM_REGS-1:0] retire;
  logic [NUM_REGS-1:0] pend_nxt;
  logic                iss_hit;

  always_comb begin
    retire  = '0;
    iss_hit = 1'b0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_we_i[p] && (wr_addr[p] != '0)) begin
        retire[wr_addr[p]] = 1'b1;
        if (wr_addr[p] == iss_addr_i) iss_hit = 1'b1;
      end
    end
  end

  // A same-cycle write to the destination frees it in time for the new owner.
  assign iss_ready_co = rst_i |
                        (!flush_i & ((iss_addr_i == '0) | !pend[iss_addr_i] | iss_hit));

  always_comb begin
    pend_nxt = pend & ~retire;
    if (iss_valid_i && iss_ready_co && (iss_addr_i != '0)) pend_nxt[iss_addr_i] = 1'b1;
    if (flush_i) pend_nxt = '0;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend <= '0;
    else       pend <= pend_nxt;
  end
endmodule

// File: rtl/jedro_1_regfile_sb.sv
// Multi-port integer register file with optional write bypass and an embedded busy-bit scoreboard.
module jedro_1_regfile_sb
  import jedro_1_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_RD_PORTS   = 2,
  parameter int NUM_WR_PORTS   = 2,
  parameter int BYPASS         = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     rd_data_co,
  output logic [NUM_RD_PORTS-1:0]                rd_pend_co,
  input  logic [NUM_WR_PORTS*REG_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]     wr_data_i,
  input  logic [NUM_WR_PORTS-1:0]                wr_we_i,
  input  logic [REG_ADDR_WIDTH-1:0]              iss_addr_i,
  input  logic                                   iss_valid_i,
  output logic                                   iss_ready_co,
  input  logic                                   flush_i
);
  logic [DATA_WIDTH-1:0]     regs    [NUM_REGS];
  logic [REG_ADDR_WIDTH-1:0] rd_addr [NUM_RD_PORTS];
  logic [REG_ADDR_WIDTH-1:0] wr_addr [NUM_WR_PORTS];
  logic [DATA_WIDTH-1:0]     wr_data [NUM_WR_PORTS];
  logic [NUM_REGS-1:0]       pend;
  logic                      byp_hit;
  logic [DATA_WIDTH-1:0]     byp_data;

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd_unpack
    assign rd_addr[k] = REG_ADDR_WIDTH'(port_slice(SLICE_VEC_W'(rd_addr_i), k, REG_ADDR_WIDTH));
  end

  for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_wr_unpack
    assign wr_addr[p] = REG_ADDR_WIDTH'(port_slice(SLICE_VEC_W'(wr_addr_i), p, REG_ADDR_WIDTH));
    assign wr_data[p] = DATA_WIDTH'(port_slice(SLICE_VEC_W'(wr_data_i), p, DATA_WIDTH));
  end

  // Ascending port order: the last nonblocking write to an address, i.e. the highest port, wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_we_i[p] && (wr_addr[p] != '0)) regs[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  always_comb begin
    rd_data_co = '0;
    rd_pend_co = '0;
    byp_hit    = 1'b0;
    byp_data   = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_we_i[p] && (wr_addr[p] != '0) && (wr_addr[p] == rd_addr[k])) begin
          byp_hit  = 1'b1;
          byp_data = wr_data[p];
        end
      end
      if ((BYPASS != 0) && byp_hit) rd_data_co[k*DATA_WIDTH +: DATA_WIDTH] = byp_data;
      else                          rd_data_co[k*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr[k]];
      rd_pend_co[k] = pend[rd_addr[k]] && !((BYPASS != 0) && byp_hit);
      if (rst_i || (rd_addr[k] == '0)) begin
        rd_data_co[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_pend_co[k]                          = 1'b0;
      end
    end
  end

  jedro_1_scoreboard #(
    .NUM_REGS      (NUM_REGS),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .NUM_WR_PORTS  (NUM_WR_PORTS)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_addr     (wr_addr),
    .wr_we_i     (wr_we_i),
    .iss_addr_i  (iss_addr_i),
    .iss_valid_i (iss_valid_i),
    .flush_i     (flush_i),
    .iss_ready_co(iss_ready_co),
    .pend        (pend)
  );
endmodule

// File: tb/tb_jedro_1_regfile_sb.sv
// Directed bench for jedro_1_regfile_sb: bypass and non-bypass instances share stimulus.
module tb_jedro_1_regfile_sb;
  import jedro_1_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_pend, rd_pend_nb;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [1:0]  wr_we = '0;
  logic [4:0]  iss_addr = '0;
  logic        iss_valid = 1'b0;
  logic        iss_ready, iss_ready_nb;
  logic        flush = 1'b0;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jedro_1_regfile_sb #(.BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_co(rd_data), .rd_pend_co(rd_pend),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_we_i(wr_we), .iss_addr_i(iss_addr),
    .iss_valid_i(iss_valid), .iss_ready_co(iss_ready), .flush_i(flush)
  );

  jedro_1_regfile_sb #(.BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_co(rd_data_nb), .rd_pend_co(rd_pend_nb),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_we_i(wr_we), .iss_addr_i(iss_addr),
    .iss_valid_i(iss_valid), .iss_ready_co(iss_ready_nb), .flush_i(flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow: observed %0h with no queued expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive_wr(input int p, input reg_addr_t a, input logic [31:0] d);
    wr_we[p]           = 1'b1;
    wr_addr[p*5 +: 5]  = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic clr_wr();
    wr_we = '0;
  endtask

  task automatic rd_sel(input reg_addr_t a0, input reg_addr_t a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      rd_sel(reg_addr_t'(a), reg_addr_t'(31 - a));
      push("rst_rd0", 32'h0);
      push("rst_rd1", 32'h0);
      push("rst_pend", 32'h0);
      #1;
      pop_chk(rd_data[31:0]);
      pop_chk(rd_data[63:32]);
      pop_chk(32'(rd_pend));
    end
    iss_addr = 5'd5;
    drive_wr(0, 5'd5, 32'hDEADBEEF);
    rd_sel(5'd5, 5'd5);
    push("rst_iss_ready", 32'h1);
    push("rst_byp_gated", 32'h0);
    #1;
    pop_chk(32'(iss_ready));
    pop_chk(rd_data[31:0]);
    clr_wr();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Same-cycle bypass versus next-cycle visibility
    drive_wr(0, 5'd5, 32'hDEADBEEF);
    rd_sel(5'd5, 5'd5);
    push("byp_same_cycle", 32'hDEADBEEF);
    push("nobyp_same_cycle", 32'h0);
    settle();
    pop_chk(rd_data[31:0]);
    pop_chk(rd_data_nb[31:0]);
    tick();
    clr_wr();
    push("byp_next_cycle", 32'hDEADBEEF);
    push("nobyp_next_cycle", 32'hDEADBEEF);
    settle();
    pop_chk(rd_data[31:0]);
    pop_chk(rd_data_nb[31:0]);

    // Write-port priority and x0 discard
    tick();
    drive_wr(0, 5'd7, 32'h11111111);
    drive_wr(1, 5'd7, 32'h22222222);
    rd_sel(5'd7, 5'd7);
    push("prio_byp_p0", 32'h22222222);
    push("prio_byp_p1", 32'h22222222);
    settle();
    pop_chk(rd_data[31:0]);
    pop_chk(rd_data[63:32]);
    tick();
    clr_wr();
    drive_wr(0, 5'd0, 32'hFFFFFFFF);
    rd_sel(5'd7, 5'd0);
    push("prio_stored", 32'h22222222);
    push("prio_stored_nb", 32'h22222222);
    push("x0_byp", 32'h0);
    settle();
    pop_chk(rd_data[31:0]);
    pop_chk(rd_data_nb[31:0]);
    pop_chk(rd_data[63:32]);
    tick();
    clr_wr();
    push("x0_stored", 32'h0);
    push("x0_stored_nb", 32'h0);
    settle();
    pop_chk(rd_data[63:32]);
    pop_chk(rd_data_nb[63:32]);

    // Issue, WAW stall, write-during-reissue
    tick();
    iss_addr  = 5'd3;
    iss_valid = 1'b1;
    rd_sel(5'd3, 5'd0);
    push("iss3_ready", 32'h1);
    push("iss3_pend_before", 32'h0);
    settle();
    pop_chk(32'(iss_ready));
    pop_chk(32'(rd_pend[0]));
    tick();
    push("reiss3_ready", 32'h0);
    push("iss3_pend_after", 32'h1);
    settle();
    pop_chk(32'(iss_ready));
    pop_chk(32'(rd_pend[0]));
    tick();
    drive_wr(0, 5'd3, 32'h5);
    push("reiss3_wr_ready", 32'h1);
    push("reiss3_wr_ready_nb", 32'h1);
    push("wr3_pend_byp", 32'h0);
    push("wr3_pend_nb", 32'h1);
    push("wr3_data_byp", 32'h5);
    settle();
    pop_chk(32'(iss_ready));
    pop_chk(32'(iss_ready_nb));
    pop_chk(32'(rd_pend[0]));
    pop_chk(32'(rd_pend_nb[0]));
    pop_chk(rd_data[31:0]);
    tick();
    clr_wr();
    iss_valid = 1'b0;
    push("set_wins_pend", 32'h1);
    push("set_wins_data", 32'h5);
    settle();
    pop_chk(32'(rd_pend[0]));
    pop_chk(rd_data[31:0]);
    tick();
    drive_wr(1, 5'd3, 32'h6);
    tick();
    clr_wr();
    push("retire3_pend", 32'h0);
    push("retire3_data", 32'h6);
    push("retire3_data_nb", 32'h6);
    settle();
    pop_chk(32'(rd_pend[0]));
    pop_chk(rd_data[31:0]);
    pop_chk(rd_data_nb[31:0]);

    // x0 is never pending
    tick();
    iss_addr  = 5'd0;
    iss_valid = 1'b1;
    rd_sel(5'd0, 5'd0);
    push("iss0_ready", 32'h1);
    settle();
    pop_chk(32'(iss_ready));
    tick();
    iss_valid = 1'b0;
    push("iss0_pend", 32'h0);
    settle();
    pop_chk(32'(rd_pend));

    // Several in flight, then flush with a competing issue
    tick();
    iss_addr  = 5'd4;
    iss_valid = 1'b1;
    tick();
    iss_addr = 5'd9;
    tick();
    iss_addr = 5'd12;
    tick();
    rd_sel(5'd4, 5'd9);
    push("pre_flush_pend", 32'h3);
    iss_addr = 5'd15;
    flush    = 1'b1;
    push("flush_ready", 32'h0);
    settle();
    pop_chk(32'(rd_pend));
    pop_chk(32'(iss_ready));
    tick();
    flush     = 1'b0;
    iss_valid = 1'b0;
    iss_addr  = 5'd12;
    rd_sel(5'd12, 5'd15);
    push("post_flush_pend_12_15", 32'h0);
    push("post_flush_ready", 32'h1);
    settle();
    pop_chk(32'(rd_pend));
    pop_chk(32'(iss_ready));
    rd_sel(5'd4, 5'd9);
    push("post_flush_pend_4_9", 32'h0);
    #1;
    pop_chk(32'(rd_pend));

    // Asynchronous reset between edges
    tick();
    drive_wr(0, 5'd8, 32'hABCD);
    tick();
    clr_wr();
    iss_addr  = 5'd8;
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    rd_sel(5'd8, 5'd8);
    push("pre_rst_data", 32'hABCD);
    push("pre_rst_pend", 32'h3);
    settle();
    pop_chk(rd_data[31:0]);
    pop_chk(32'(rd_pend));
    rst = 1'b1;
    push("async_rst_data", 32'h0);
    push("async_rst_data_nb", 32'h0);
    push("async_rst_pend", 32'h0);
    #1;
    pop_chk(rd_data[31:0]);
    pop_chk(rd_data_nb[31:0]);
    pop_chk(32'(rd_pend));
    @(negedge clk);
    rst = 1'b0;
    tick();
    push("after_rst_data", 32'h0);
    push("after_rst_pend", 32'h0);
    settle();
    pop_chk(rd_data[31:0]);
    pop_chk(32'(rd_pend));

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: observed %0d queued, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
